// File: rtl/clamp_pad_pkg.sv
// ============================================================================
// Module  : clamp_pad_pkg
// Brief   : Shared FSM state type and line-geometry helpers for the
//           edge-clamp padding stream stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package clamp_pad_pkg;

    typedef enum logic [1:0] {
        ST_LEFT  = 2'd0,
        ST_BODY  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    // Padded line length in beats.
    function automatic int line_len(input int pad_l, input int img_w, input int pad_r);
        return pad_l + img_w + pad_r;
    endfunction

    function automatic int cnt_w(input int l);
        return $clog2(l + 1);
    endfunction

endpackage : clamp_pad_pkg

`default_nettype wire

// File: rtl/clamp_pad_out_slice.sv
// ============================================================================
// Module  : clamp_pad_out_slice
// Brief   : Registered data/valid/sol/eol output stage with its load enable.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module clamp_pad_out_slice #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_emit,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_sol,
    input  logic             i_eol,
    input  logic             i_ready,
    output logic             o_ld,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_sol,
    output logic             o_eol
);

    assign o_ld = !o_valid || i_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sol   <= 1'b0;
            o_eol   <= 1'b0;
        end else if (o_ld) begin
            o_valid <= i_emit;
            o_data  <= i_data;
            o_sol   <= i_emit && i_sol;
            o_eol   <= i_emit && i_eol;
        end
    end

endmodule : clamp_pad_out_slice

`default_nettype wire

// File: rtl/clamp_pad_stream.sv
// ============================================================================
// Module  : clamp_pad_stream
// Brief   : Extends each IMG_W-pixel line with PAD_L/PAD_R edge-replicated
//           beats. Define CLAMP_PAD_ZERO_FILL_EN to emit zero pads instead.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module clamp_pad_stream
    import clamp_pad_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMG_W = 64,
    parameter int PAD_L = 1,
    parameter int PAD_R = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sol,
    output logic             out_eol
);

    localparam int c_L  = line_len(PAD_L, IMG_W, PAD_R);
    localparam int c_CW = cnt_w(c_L);

    localparam logic [c_CW-1:0] c_LEFT_END = c_CW'((PAD_L > 0) ? PAD_L - 1 : 0);
    localparam logic [c_CW-1:0] c_BODY_END = c_CW'(PAD_L + IMG_W - 1);
    localparam logic [c_CW-1:0] c_LINE_END = c_CW'(c_L - 1);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);

    // With no left padding a line starts directly in BODY.
    localparam state_t c_LINE_START = (PAD_L > 0) ? ST_LEFT : ST_BODY;
    localparam state_t c_AFTER_BODY = (PAD_R > 0) ? ST_RIGHT : c_LINE_START;

    state_t            r_state;
    logic [c_CW-1:0]   r_col_cnt;
    logic              w_ld;
    logic              w_emit;
    logic [WIDTH-1:0]  w_emit_data;
    logic [WIDTH-1:0]  w_left_data;
    logic [WIDTH-1:0]  w_right_data;
    logic              w_sol;
    logic              w_eol;

`ifdef CLAMP_PAD_ZERO_FILL_EN
    assign w_left_data  = '0;
    assign w_right_data = '0;
`else
    logic [WIDTH-1:0]  r_last_pix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_pix <= '0;
        end else if (w_emit && (r_state == ST_BODY)) begin
            r_last_pix <= in_data;
        end
    end

    assign w_left_data  = in_data;
    assign w_right_data = r_last_pix;
`endif

    assign w_sol = (r_col_cnt == '0);
    assign w_eol = (r_col_cnt == c_LINE_END);

    // LEFT peeks at the pending pixel without consuming it; RIGHT needs no input.
    always_comb begin
        in_ready    = 1'b0;
        w_emit      = 1'b0;
        w_emit_data = in_data;
        case (r_state)
            ST_LEFT: begin
                w_emit      = in_valid && w_ld;
                w_emit_data = w_left_data;
            end
            ST_BODY: begin
                in_ready    = w_ld && !reset;
                w_emit      = in_valid && w_ld && !reset;
                w_emit_data = in_data;
            end
            ST_RIGHT: begin
                w_emit      = w_ld;
                w_emit_data = w_right_data;
            end
            default: begin
                w_emit = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_LINE_START;
            r_col_cnt <= '0;
        end else if (w_emit) begin
            r_col_cnt <= (r_col_cnt == c_LINE_END) ? '0 : r_col_cnt + c_ONE;
            case (r_state)
                ST_LEFT:  if (r_col_cnt == c_LEFT_END) r_state <= ST_BODY;
                ST_BODY:  if (r_col_cnt == c_BODY_END) r_state <= c_AFTER_BODY;
                ST_RIGHT: if (r_col_cnt == c_LINE_END) r_state <= c_LINE_START;
                default:  r_state <= c_LINE_START;
            endcase
        end
    end

    clamp_pad_out_slice #(
        .WIDTH (WIDTH)
    ) u_out_slice (
        .clk     (clk),
        .reset   (reset),
        .i_emit  (w_emit),
        .i_data  (w_emit_data),
        .i_sol   (w_sol),
        .i_eol   (w_eol),
        .i_ready (out_ready),
        .o_ld    (w_ld),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_sol   (out_sol),
        .o_eol   (out_eol)
    );

endmodule : clamp_pad_stream

`default_nettype wire

// File: tb/tb_clamp_pad_stream.sv
// ============================================================================
// Module  : tb_clamp_pad_stream
// Brief   : Scoreboard bench for clamp_pad_stream (IMG_W=4/PAD 1,2 and a
//           degenerate IMG_W=1/PAD 0,0 instance).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clamp_pad_stream;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sol;
    logic        out_eol;

    logic [15:0] in1_data;
    logic        in1_valid;
    logic        in1_ready;
    logic [15:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic        out1_sol;
    logic        out1_eol;

    int checks = 0;
    int errors = 0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];
    bit          sb_en = 1'b1;
    bit          bp_en = 1'b0;
    int          bp_idx = 0;
    bit          stall_prev = 1'b0;
    logic [15:0] held = '0;
    int          run = 0;
    int          max_run = 0;

    clamp_pad_stream #(
        .WIDTH (16), .IMG_W (4), .PAD_L (1), .PAD_R (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sol   (out_sol),
        .out_eol   (out_eol)
    );

    clamp_pad_stream #(
        .WIDTH (16), .IMG_W (1), .PAD_L (0), .PAD_R (0)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in1_data),
        .in_valid  (in1_valid),
        .in_ready  (in1_ready),
        .out_data  (out1_data),
        .out_valid (out1_valid),
        .out_ready (out1_ready),
        .out_sol   (out1_sol),
        .out_eol   (out1_eol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Downstream ready: pattern 1,0,0,1 while backpressure is enabled.
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            out_ready = ((bp_idx % 4) == 0) || ((bp_idx % 4) == 3);
            bp_idx++;
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
            run        = 0;
        end else begin
            if (stall_prev)
                check(out_valid && (out_data == held), "stall_hold", {15'b0, out_valid, out_data}, {16'h0001, held});
            if (out_valid && !out_ready) begin
                check(!in_ready, "stall_in_ready", 32'(in_ready), 32'd0);
                held       = out_data;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            run = out_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (out_valid && out_ready && sb_en) begin
                if (q0.size() == 0) begin
                    check(1'b0, "extra_beat", {14'b0, out_data, out_sol, out_eol}, 32'd0);
                end else begin
                    logic [17:0] e;
                    e = q0.pop_front();
                    check({out_data, out_sol, out_eol} == e, "beat", {14'b0, out_data, out_sol, out_eol}, {14'b0, e});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out1_valid && out1_ready) begin
            if (q1.size() == 0) begin
                check(1'b0, "extra_beat1", {14'b0, out1_data, out1_sol, out1_eol}, 32'd0);
            end else begin
                logic [17:0] e;
                e = q1.pop_front();
                check({out1_data, out1_sol, out1_eol} == e, "beat1", {14'b0, out1_data, out1_sol, out1_eol}, {14'b0, e});
            end
        end
    end

    task automatic send_px(input logic [15:0] d);
        bit acc;
        acc      = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) check(1'b0, "send_timeout", 32'(d), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [15:0] p0, p1, p2, p3);
        logic [15:0] lp, rp;
`ifdef CLAMP_PAD_ZERO_FILL_EN
        lp = 16'h0;
        rp = 16'h0;
`else
        lp = p0;
        rp = p3;
`endif
        q0.push_back({lp, 2'b10});
        q0.push_back({p0, 2'b00});
        q0.push_back({p1, 2'b00});
        q0.push_back({p2, 2'b00});
        q0.push_back({p3, 2'b00});
        q0.push_back({rp, 2'b00});
        q0.push_back({rp, 2'b01});
    endtask

    task automatic send_line(input logic [15:0] p0, p1, p2, p3, input bit gap);
        push_line(p0, p1, p2, p3);
        send_px(p0);
        send_px(p1);
        if (gap) begin
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            check(!out_valid, "gap_drop", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        send_px(p2);
        send_px(p3);
    endtask

    task automatic drain;
        for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++)
            @(negedge clk);
        check(q0.size() == 0 && q1.size() == 0, "drain", 32'(q0.size() + q1.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in1_data  = '0;
        in1_valid = 1'b0;
        out1_ready = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check(!out_valid && out_data == 16'h0 && !out_sol && !out_eol, "reset_out",
              {14'b0, out_data, out_sol, out_eol} | (32'(out_valid) << 20), 32'd0);
        check(!in_ready, "reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single line with first-beat latency.
        fork
            send_line(16'd10, 16'd20, 16'd30, 16'd40, 1'b0);
            begin
                @(negedge clk);
                check(!out_valid, "lat_pre", 32'(out_valid), 32'd0);
                @(negedge clk);
                check(out_valid, "lat_first", 32'(out_valid), 32'd1);
            end
        join
        in_valid = 1'b0;
        drain();

        // Two back-to-back lines without bubbles.
        max_run = 0;
        send_line(16'd10, 16'd20, 16'd30, 16'd40, 1'b0);
        send_line(16'd50, 16'd60, 16'd70, 16'd80, 1'b0);
        in_valid = 1'b0;
        drain();
        check(max_run == 14, "no_bubble", 32'(max_run), 32'd14);

        // Backpressure.
        bp_en = 1'b1;
        send_line(16'd100, 16'd200, 16'd300, 16'd400, 1'b0);
        send_line(16'd11, 16'd22, 16'd33, 16'd44, 1'b0);
        in_valid = 1'b0;
        drain();
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Input gap between pixels 20 and 30.
        send_line(16'd10, 16'd20, 16'd30, 16'd40, 1'b1);
        in_valid = 1'b0;
        drain();

        // Reset mid-line, then a clean line.
        sb_en = 1'b0;
        send_px(16'd5);
        send_px(16'd6);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check(!out_valid && out_data == 16'h0 && !out_sol && !out_eol, "midreset_out",
              {14'b0, out_data, out_sol, out_eol} | (32'(out_valid) << 20), 32'd0);
        check(!in_ready, "midreset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        sb_en = 1'b1;
        send_line(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        in_valid = 1'b0;
        drain();

        // IMG_W=1, no padding: every beat is both sol and eol.
        for (int i = 0; i < 3; i++) begin
            bit acc;
            acc = 1'b0;
            q1.push_back({16'(7 + i), 2'b11});
            in1_data  = 16'(7 + i);
            in1_valid = 1'b1;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (in1_ready) begin
                    acc = 1'b1;
                    break;
                end
            end
            if (!acc) check(1'b0, "send1_timeout", 32'(i), 32'd0);
            @(posedge clk);
            #1;
        end
        in1_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clamp_pad_stream

`default_nettype wire
